// File: rtl/regfl_wr_arb.sv
// Round-robin arbiter sharing the register file's single write port among NREQ requesters.
// A grant takes two cycles: the winner's address and data are latched, then committed on the next edge.
module regfl_wr_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 64,
  parameter int AW   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    addr,
  input  logic [NREQ*DW-1:0]    data,
  input  logic                  clr,
  output logic [NREQ-1:0]       ack,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_s,
  output logic [DW-1:0]         rf_d,
  output logic                  busy,
  output logic [(2**AW)-1:0]    valid
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 2**AW;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   win_r;
  logic [PW-1:0]   win_s;
  logic            hit_s;

  logic [NREQ-1:0]  ack_next_s;
  logic             rf_we_next_s;
  logic [AW-1:0]    rf_s_next_s;
  logic [DW-1:0]    rf_d_next_s;
  logic             busy_next_s;
  logic [DEPTH-1:0] valid_next_s;
  logic [PW-1:0]    ptr_next_s;
  logic [PW-1:0]    win_next_s;

  // Round-robin search: first set request at or after ptr, wrapping modulo NREQ
  always_comb begin
    int idx;
    idx   = 0;
    win_s = ptr_r;
    hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!hit_s && req[idx]) begin
        hit_s = 1'b1;
        win_s = PW'(idx);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; req is only looked at in IDLE
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE:    state_next_s = hit_s ? WRITE : IDLE;
      WRITE:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration state
  always_comb begin
    ack_next_s   = {NREQ{1'b0}};
    rf_we_next_s = 1'b0;
    busy_next_s  = 1'b0;
    rf_s_next_s  = rf_s;
    rf_d_next_s  = rf_d;
    ptr_next_s   = ptr_r;
    win_next_s   = win_r;
    valid_next_s = clr ? {DEPTH{1'b0}} : valid;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          ack_next_s[win_s] = 1'b1;
          rf_we_next_s      = 1'b1;
          busy_next_s       = 1'b1;
          rf_s_next_s       = addr[int'(win_s)*AW +: AW];
          rf_d_next_s       = data[int'(win_s)*DW +: DW];
          win_next_s        = win_s;
        end else begin
          win_next_s = win_r;
        end
      end
      WRITE: begin
        // Clear takes effect first so the committed bit survives a same-cycle clr
        valid_next_s[rf_s] = 1'b1;
        if (win_r == PW'(NREQ - 1)) begin
          ptr_next_s = {PW{1'b0}};
        end else begin
          ptr_next_s = win_r + {{(PW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        ptr_next_s = ptr_r;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= {NREQ{1'b0}};
      rf_we <= 1'b0;
      busy  <= 1'b0;
      rf_s  <= {AW{1'b0}};
      rf_d  <= {DW{1'b0}};
      valid <= {DEPTH{1'b0}};
      ptr_r <= {PW{1'b0}};
      win_r <= {PW{1'b0}};
    end else begin
      ack   <= ack_next_s;
      rf_we <= rf_we_next_s;
      busy  <= busy_next_s;
      rf_s  <= rf_s_next_s;
      rf_d  <= rf_d_next_s;
      valid <= valid_next_s;
      ptr_r <= ptr_next_s;
      win_r <= win_next_s;
    end
  end

endmodule
